// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: states, opcodes,
// ALU operation codes, datapath mux selects and small decode helpers.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_UPPER,
        S_TRAP
    } state_t;

    // Which flavour of ALU decode the current state needs.
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_R,
        ALU_CLS_I,
        ALU_CLS_BR
    } alu_cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_OR   = 4'b1100;
    localparam logic [3:0] ALU_AND  = 4'b1110;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALUY   = 2'b10;
    localparam logic [1:0] RES_PC     = 2'b11;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam int unsigned RST_CNT_W = 4;

    // funct3 encodings that have no RV32I meaning for the given opcode.
    function automatic logic funct3_illegal(input logic [6:0] opcode, input logic [2:0] f3);
        logic bad;
        bad = 1'b0;
        case (opcode)
            OP_LOAD:   bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            OP_STORE:  bad = (f3 >= 3'b011);
            OP_BRANCH: bad = (f3[2:1] == 2'b01);
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

    // beq/bge/bgeu take on zero=1; bne/blt/bltu take on zero=0.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        return zero ^ (f3[2] ^ f3[0]);
    endfunction

endpackage

// File: rtl/control_alu_dec.sv
// Maps the state class plus funct3/instr[30] to the 4-bit ALU operation select.
module control_alu_dec
    import ctrl_pkg::*;
(
    input  alu_cls_t   cls_i,
    input  logic [2:0] funct3_i,
    input  logic       instr30_i,
    output logic [3:0] alu_sel_o
);

    logic [3:0] base_op;

    always_comb begin
        base_op = ALU_ADD;
        case (funct3_i)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    end

    always_comb begin
        alu_sel_o = ALU_ADD;
        case (cls_i)
            ALU_CLS_R: begin
                if (funct3_i == 3'b000)
                    alu_sel_o = instr30_i ? ALU_SUB : ALU_ADD;
                else if (funct3_i == 3'b101)
                    alu_sel_o = instr30_i ? ALU_SRA : ALU_SRL;
                else
                    alu_sel_o = base_op;
            end
            ALU_CLS_I: begin
                // instr[30] in addi is immediate data, so only shifts look at it.
                if (funct3_i == 3'b101 && instr30_i)
                    alu_sel_o = ALU_SRA;
                else
                    alu_sel_o = base_op;
            end
            ALU_CLS_BR: begin
                case (funct3_i[2:1])
                    2'b10:   alu_sel_o = ALU_SLT;
                    2'b11:   alu_sel_o = ALU_SLTU;
                    default: alu_sel_o = ALU_SUB;
                endcase
            end
            default: alu_sel_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing
// with Moore-decoded datapath controls and a sticky illegal-instruction trap.
module control_multiciclo
    import ctrl_pkg::*;
#(
    parameter int unsigned RESET_FETCH_DELAY = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_valid,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [1:0]  src_a_sel,
    output logic [1:0]  src_b_sel,
    output logic [1:0]  res_sel,
    output logic [2:0]  imm_sel,
    output logic [3:0]  alu_sel,
    output logic        illegal
);

    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RESET_FETCH_DELAY - 1);

    state_t               state_q, state_d, decode_target;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    alu_cls_t             alu_cls;
    logic [3:0]           alu_op;
    logic                 unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            rst_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    always_comb begin
        decode_target = S_TRAP;
        if (!funct3_illegal(opcode, funct3)) begin
            case (opcode)
                OP_R:              decode_target = S_EXEC_R;
                OP_IMM:            decode_target = S_EXEC_I;
                OP_LOAD, OP_STORE: decode_target = S_MEM_ADDR;
                OP_BRANCH:         decode_target = S_BRANCH;
                OP_JAL:            decode_target = S_JAL;
                OP_JALR:           decode_target = S_JALR;
                OP_LUI, OP_AUIPC:  decode_target = S_UPPER;
                default:           decode_target = S_TRAP;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = '0;
        case (state_q)
            S_RESET: begin
                if (rst_cnt_q == RST_LAST)
                    state_d = S_FETCH;
                else
                    rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
            end
            S_FETCH:            if (mem_ready) state_d = S_DECODE;
            S_DECODE:           state_d = decode_target;
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADDR:         state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:         if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE:        if (mem_ready) state_d = S_FETCH;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR, S_UPPER:
                                state_d = S_FETCH;
            S_TRAP:             state_d = S_TRAP;
            default:            state_d = S_RESET;
        endcase
    end

    always_comb begin
        case (state_q)
            S_EXEC_R: alu_cls = ALU_CLS_R;
            S_EXEC_I: alu_cls = ALU_CLS_I;
            S_BRANCH: alu_cls = ALU_CLS_BR;
            default:  alu_cls = ALU_CLS_ADD;
        endcase
    end

    control_alu_dec u_alu_dec (
        .cls_i     (alu_cls),
        .funct3_i  (funct3),
        .instr30_i (instr[30]),
        .alu_sel_o (alu_op)
    );

    // Moore decode; only fetch enables and the branch pc_we look at inputs.
    always_comb begin
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        src_a_sel = SRC_A_PC;
        src_b_sel = SRC_B_RS2;
        res_sel   = RES_ALUOUT;
        imm_sel   = IMM_I;
        alu_sel   = ALU_ADD;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_valid = 1'b1;
                src_a_sel = SRC_A_PC;
                src_b_sel = SRC_B_FOUR;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            S_EXEC_R: begin
                src_a_sel = SRC_A_RS1;
                src_b_sel = SRC_B_RS2;
                alu_sel   = alu_op;
            end
            S_EXEC_I: begin
                src_a_sel = SRC_A_RS1;
                src_b_sel = SRC_B_IMM;
                imm_sel   = IMM_I;
                alu_sel   = alu_op;
            end
            S_ALU_WB: begin
                reg_we  = 1'b1;
                res_sel = RES_ALUOUT;
            end
            S_MEM_ADDR: begin
                src_a_sel = SRC_A_RS1;
                src_b_sel = SRC_B_IMM;
                imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEM_READ: begin
                mem_valid = 1'b1;
                addr_sel  = 1'b1;
            end
            S_MEM_WB: begin
                reg_we  = 1'b1;
                res_sel = RES_MEM;
            end
            S_MEM_WRITE: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                addr_sel  = 1'b1;
            end
            S_BRANCH: begin
                src_a_sel = SRC_A_RS1;
                src_b_sel = SRC_B_RS2;
                imm_sel   = IMM_B;
                alu_sel   = alu_op;
                pc_we     = branch_taken(funct3, zero);
            end
            S_JAL: begin
                src_a_sel = SRC_A_OLDPC;
                src_b_sel = SRC_B_IMM;
                imm_sel   = IMM_J;
                pc_we     = 1'b1;
                reg_we    = 1'b1;
                res_sel   = RES_PC;
            end
            S_JALR: begin
                src_a_sel = SRC_A_RS1;
                src_b_sel = SRC_B_IMM;
                imm_sel   = IMM_I;
                pc_we     = 1'b1;
                reg_we    = 1'b1;
                res_sel   = RES_PC;
            end
            S_UPPER: begin
                src_a_sel = (opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_OLDPC;
                src_b_sel = SRC_B_IMM;
                imm_sel   = IMM_U;
                reg_we    = 1'b1;
                res_sel   = RES_ALUY;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: per-cycle vector table plus hand-written
// trap, reset-pulse and reset-during-store sequences.
module tb_control_multiciclo;

    localparam int unsigned DLY = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_valid, mem_we, addr_sel, ir_we, pc_we, reg_we, illegal;
    logic [1:0]  src_a_sel, src_b_sel, res_sel;
    logic [2:0]  imm_sel;
    logic [3:0]  alu_sel;

    control_multiciclo #(.RESET_FETCH_DELAY(DLY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .reg_we    (reg_we),
        .src_a_sel (src_a_sel),
        .src_b_sel (src_b_sel),
        .res_sel   (res_sel),
        .imm_sel   (imm_sel),
        .alu_sel   (alu_sel),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Output vector: {mv,we,as,ir,pc,rw}, src_a, src_b, res, imm, alu, illegal
    localparam logic [19:0] Z    = 20'h0;
    localparam logic [19:0] F1   = {6'b100110, 2'b00, 2'b10, 2'b00, 3'd0, 4'b0000, 1'b0};
    localparam logic [19:0] F0   = {6'b100000, 2'b00, 2'b10, 2'b00, 3'd0, 4'b0000, 1'b0};
    localparam logic [19:0] WB   = {6'b000001, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0000, 1'b0};
    localparam logic [19:0] MA_I = {6'b000000, 2'b10, 2'b01, 2'b00, 3'd0, 4'b0000, 1'b0};
    localparam logic [19:0] MA_S = {6'b000000, 2'b10, 2'b01, 2'b00, 3'd1, 4'b0000, 1'b0};
    localparam logic [19:0] MR   = {6'b101000, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0000, 1'b0};
    localparam logic [19:0] MWB  = {6'b000001, 2'b00, 2'b00, 2'b01, 3'd0, 4'b0000, 1'b0};
    localparam logic [19:0] MW   = {6'b111000, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0000, 1'b0};
    localparam logic [19:0] T    = {19'h0, 1'b1};

    typedef struct {
        logic [31:0] ins;
        logic        z;
        logic        rdy;
        logic [19:0] ex;
        string       nm;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [19:0] actual_outs();
        return {mem_valid, mem_we, addr_sel, ir_we, pc_we, reg_we,
                src_a_sel, src_b_sel, res_sel, imm_sel, alu_sel, illegal};
    endfunction

    task automatic check(input string nm, input logic [19:0] ex);
        logic [19:0] act;
        act = actual_outs();
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: outputs got %05h required %05h", nm, act, ex);
        end else begin
            $display("%0t ok %s outputs=%05h", $time, nm, act);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ins, input logic z, input logic rdy,
                                input logic [19:0] ex, input string nm);
        vec_t v;
        v.ins = ins; v.z = z; v.rdy = rdy; v.ex = ex; v.nm = nm;
        return v;
    endfunction

    function automatic void push(input logic [31:0] ins, input logic z, input logic rdy,
                                 input logic [19:0] ex, input string nm);
        tbl.push_back(mk(ins, z, rdy, ex, nm));
    endfunction

    // FETCH(ready), DECODE, then an execute row and a writeback row.
    function automatic void push_alu(input logic [31:0] ins, input logic [19:0] ex, input string nm);
        push(ins, 1'b0, 1'b1, F1, {nm, ".fetch"});
        push(ins, 1'b0, 1'b1, Z,  {nm, ".decode"});
        push(ins, 1'b0, 1'b1, ex, {nm, ".exec"});
        push(ins, 1'b0, 1'b1, WB, {nm, ".wb"});
    endfunction

    // Three-cycle instructions: FETCH, DECODE, one execute cycle.
    function automatic void push3(input logic [31:0] ins, input logic z, input logic [19:0] ex,
                                  input string nm);
        push(ins, 1'b0, 1'b1, F1, {nm, ".fetch"});
        push(ins, 1'b0, 1'b0, Z,  {nm, ".decode"});
        push(ins, z,    1'b0, ex, {nm, ".exec"});
    endfunction

    task automatic step(input vec_t v);
        instr     = v.ins;
        zero      = v.z;
        mem_ready = v.rdy;
        #1;
        check(v.nm, v.ex);
        @(negedge clk);
    endtask

    task automatic reset_pulse(input string nm);
        rst_n = 1'b0;
        #1;
        check(nm, Z);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(DLY); i++)
            step(mk(32'h0, 1'b0, 1'b1, Z, {nm, ".wait"}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;

        for (int i = 0; i < int'(DLY); i++) push(32'h0, 1'b0, 1'b1, Z, "rst_delay");
        push_alu(32'h002081B3, {6'b0, 2'b10, 2'b00, 2'b00, 3'd0, 4'b0000, 1'b0}, "add");
        push_alu(32'h402081B3, {6'b0, 2'b10, 2'b00, 2'b00, 3'd0, 4'b0001, 1'b0}, "sub");
        push_alu(32'h4032D293, {6'b0, 2'b10, 2'b01, 2'b00, 3'd0, 4'b1011, 1'b0}, "srai");
        push_alu(32'h0032D293, {6'b0, 2'b10, 2'b01, 2'b00, 3'd0, 4'b1010, 1'b0}, "srli");
        push_alu(32'hC0000093, {6'b0, 2'b10, 2'b01, 2'b00, 3'd0, 4'b0000, 1'b0}, "addi_neg");
        // lw with three wait cycles: 8 cycles total, one reg_we
        push(32'h0000A283, 1'b0, 1'b1, F1,   "lw.fetch");
        push(32'h0000A283, 1'b0, 1'b1, Z,    "lw.decode");
        push(32'h0000A283, 1'b0, 1'b1, MA_I, "lw.addr");
        for (int i = 0; i < 3; i++) push(32'h0000A283, 1'b0, 1'b0, MR, "lw.read_wait");
        push(32'h0000A283, 1'b0, 1'b1, MR,   "lw.read_done");
        push(32'h0000A283, 1'b0, 1'b0, MWB,  "lw.wb");
        // beq taken, preceded by two fetch wait cycles
        push(32'h00208463, 1'b0, 1'b0, F0, "beq.fetch_wait");
        push(32'h00208463, 1'b0, 1'b0, F0, "beq.fetch_wait");
        push3(32'h00208463, 1'b1, {6'b000010, 2'b10, 2'b00, 2'b00, 3'd2, 4'b0001, 1'b0}, "beq_taken");
        push3(32'h00208463, 1'b0, {6'b000000, 2'b10, 2'b00, 2'b00, 3'd2, 4'b0001, 1'b0}, "beq_not");
        push3(32'h00209463, 1'b0, {6'b000010, 2'b10, 2'b00, 2'b00, 3'd2, 4'b0001, 1'b0}, "bne_taken");
        push3(32'h0020E463, 1'b0, {6'b000010, 2'b10, 2'b00, 2'b00, 3'd2, 4'b0110, 1'b0}, "bltu_taken");
        push3(32'h0020F463, 1'b0, {6'b000000, 2'b10, 2'b00, 2'b00, 3'd2, 4'b0110, 1'b0}, "bgeu_not");
        push3(32'h010000EF, 1'b0, {6'b000011, 2'b01, 2'b01, 2'b11, 3'd4, 4'b0000, 1'b0}, "jal");
        push3(32'h00008067, 1'b0, {6'b000011, 2'b10, 2'b01, 2'b11, 3'd0, 4'b0000, 1'b0}, "jalr");
        push3(32'h123452B7, 1'b0, {6'b000001, 2'b11, 2'b01, 2'b10, 3'd3, 4'b0000, 1'b0}, "lui");
        push3(32'h12345297, 1'b0, {6'b000001, 2'b01, 2'b01, 2'b10, 3'd3, 4'b0000, 1'b0}, "auipc");
        push3(32'h0000007F, 1'b0, T, "bad_opcode");

        repeat (2) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("reset_low", Z);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i]);

        // trap is sticky and asserts nothing else, whatever the inputs do
        for (int i = 0; i < 20; i++)
            step(mk(32'h0000007F, i[1], i[0], T, "trap_hold"));

        reset_pulse("trap_clear");
        step(mk(32'h0000B283, 1'b0, 1'b1, F1, "ld_bad_f3.fetch"));
        step(mk(32'h0000B283, 1'b0, 1'b1, Z,  "ld_bad_f3.decode"));
        step(mk(32'h0000B283, 1'b0, 1'b1, T,  "ld_bad_f3.trap"));

        // reset asserted while a store is waiting on memory
        reset_pulse("pre_store");
        step(mk(32'h0020A223, 1'b0, 1'b1, F1,   "sw.fetch"));
        step(mk(32'h0020A223, 1'b0, 1'b1, Z,    "sw.decode"));
        step(mk(32'h0020A223, 1'b0, 1'b1, MA_S, "sw.addr"));
        step(mk(32'h0020A223, 1'b0, 1'b0, MW,   "sw.write_wait"));
        #1;
        check("sw.write_wait2", MW);
        #2;
        rst_n = 1'b0;
        #1;
        check("sw.async_reset", Z);
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(DLY); i++)
            step(mk(32'h002081B3, 1'b0, 1'b1, Z, "post_reset.wait"));
        step(mk(32'h002081B3, 1'b0, 1'b1, F1, "post_reset.first_fetch"));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
- Multicycle RV32I control unit. It sits directly upstream of the ALU and drives its 4-bit operation select, operand muxes and datapath write enables.
- It sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- It consumes the ALU zero flag to resolve branches.
- It handshakes with a single shared instruction/data memory port.

Parameters:
- RESET_FETCH_DELAY, 1, idle cycles spent in S_RESET after rst_n deasserts, before the first fetch (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  instruction register contents (valid from DECODE onward).
- zero  in  1  ALU zero flag for the current cycle's ALU result.
- mem_ready  in  1  memory completes the access this cycle.
- mem_valid  out  1  memory access request.
- mem_we  out  1  memory write (qualified by mem_valid).
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALU-out register.
- ir_we  out  1  load IR and old-PC registers.
- pc_we  out  1  load PC from ALU Y.
- reg_we  out  1  register-file write.
- src_a_sel  out  2  ALU A operand: 00 = PC, 01 = old PC, 10 = rs1, 11 = zero.
- src_b_sel  out  2  ALU B operand: 00 = rs2, 01 = immediate, 10 = constant 4.
- res_sel  out  2  writeback source: 00 = ALU-out register, 01 = memory data, 10 = ALU Y direct, 11 = PC.
- imm_sel  out  3  immediate format: I = 0, S = 1, B = 2, U = 3, J = 4.
- alu_sel  out  4  ALU operation, encoded as {funct3-style op, modifier}.
- illegal  out  1  sticky trap flag.

Behaviour:
- Reset: async. State becomes S_RESET. Every output is 0 while rst_n is low and while in S_RESET.
- Outputs are Moore decodes of the state. Exceptions: pc_we in S_BRANCH, and the mem_ready-qualified enables listed below.
- ALU encoding:
  - alu_sel[3:1]: 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and.
  - alu_sel[0]: 1 means subtract or arithmetic right shift.
- R-type: alu_sel = {funct3, instr[30] for funct3 = 000 or 101, else 0}.
- OP-IMM: alu_sel[0] = instr[30] only for funct3 = 101; addi never subtracts.
- S_RESET: count RESET_FETCH_DELAY cycles, then go to S_FETCH.
- S_FETCH:
  - mem_valid = 1, addr_sel = 0, src_a = PC, src_b = 4, alu_sel = 0000.
  - Hold until mem_ready. In the mem_ready cycle, ir_we = pc_we = 1, then go to S_DECODE.
- S_DECODE: one cycle. Dispatch on instr[6:0]:
  - 0110011 → S_EXEC_R.
  - 0010011 → S_EXEC_I.
  - 0000011 / 0100011 → S_MEM_ADDR.
  - 1100011 → S_BRANCH.
  - 1101111 → S_JAL.
  - 1100111 → S_JALR.
  - 0110111 / 0010111 → S_UPPER.
  - Anything else → S_TRAP.
- Illegal funct3 also goes to S_TRAP: loads 011/110/111, stores ≥011, branches 010/011.
- S_EXEC_R / S_EXEC_I: src_a = rs1, src_b = rs2 / imm. Result latched into ALU-out. Next state is S_ALU_WB.
- S_ALU_WB: reg_we = 1, res_sel = 00. Next state is S_FETCH.
- S_MEM_ADDR: rs1 + imm (imm I for loads, S for stores) latched into ALU-out. Next is S_MEM_READ or S_MEM_WRITE.
- S_MEM_READ: mem_valid = 1, addr_sel = 1. Hold until mem_ready, then go to S_MEM_WB.
- S_MEM_WB: reg_we = 1, res_sel = 01. Next state is S_FETCH.
- S_MEM_WRITE: mem_valid = mem_we = addr_sel = 1. Hold until mem_ready, then go to S_FETCH.
- S_BRANCH: one cycle.
  - Compare src_a = rs1, src_b = rs2:
    - beq/bne use alu_sel 0001.
    - blt/bge use 0100.
    - bltu/bgeu use 0110.
  - Taken when:
    - beq or bge/bgeu: zero = 1.
    - bne or blt/bltu: zero = 0.
  - Branch target computed by the datapath adder: old PC + imm B.
  - pc_we = taken. Next state is S_FETCH.
- S_JAL / S_JALR: one cycle.
  - src_a = old PC (JAL) or rs1 (JALR), src_b = imm J/I, add.
  - pc_we = 1, reg_we = 1, res_sel = 11 (rd ← current PC = old PC + 4).
  - The datapath clears bit 0 of the JALR target.
- S_UPPER: one cycle. src_a = zero (LUI) or old PC (AUIPC), src_b = imm U, add. reg_we = 1, res_sel = 10. Next state is S_FETCH.
- S_TRAP: illegal = 1. All enables 0. Held until reset.
- Latency in cycles, with mem_ready immediate: R/I 4, load 5, store 4, branch/JAL/JALR/upper 3. Each wait cycle on mem_ready adds 1.
- mem_ready while mem_valid = 0: ignored.
- Reset mid-access: mem_valid drops asynchronously. No write completes. No register write occurs.

Decomposition:
- Package ctrl_pkg holds:
  - State enumeration.
  - Opcode constants.
  - ALU op constants (ALU_ADD = 0000, ALU_SUB = 0001, ALU_SLT = 0100, ALU_SLTU = 0110, …).
  - Mux select constants for src_a_sel, src_b_sel, res_sel, imm_sel.
- One sub-module, control_alu_dec: combinational mapping of {state class, funct3, instr[30]} to alu_sel.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3) with mem_ready tied 1 → FETCH → DECODE → EXEC_R → ALU_WB. alu_sel = 0000 in EXEC_R, reg_we = 1 only in cycle 4. Repeat with sub (0x402081B3) → alu_sel = 0001.
- srai x5,x5,3 (0x4032D293) → alu_sel = 1011. srli (0x0032D293) → 1010. addi with instr[30] = 1 from a large negative immediate → 0000.
- lw with mem_ready delayed 3 cycles in S_MEM_READ → mem_valid = 1 and addr_sel = 1 held 3 cycles. reg_we = 1 exactly once, with res_sel = 01. Total 8 cycles.
- beq taken (zero = 1) and not taken (zero = 0). bltu with zero = 0 → pc_we = 1. bgeu with zero = 0 → pc_we = 0. alu_sel = 0110 in both bltu and bgeu.
- Opcode 0x0000007F → S_TRAP, illegal = 1 and stays set. No enables asserted for 20 cycles. rst_n pulse clears illegal.
- Assert rst_n = 0 mid S_MEM_WRITE while mem_ready = 0 → mem_valid and mem_we go to 0 before the next edge. After release, the first fetch issues after RESET_FETCH_DELAY cycles.
